// File: rtl/prng_pkg.sv
// Shared types and default constants for the PRNG stream generator.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } prng_state_t;

  localparam logic [15:0] PRNG_DEF_TAPS = 16'hB400;
  localparam logic [15:0] PRNG_DEF_SEED = 16'hACE1;

endpackage

// File: rtl/prng_lfsr_core.sv
// Fibonacci LFSR with seed load and single-step advance; chunk is the pre-shift low bits.
// Optional PRNG_ZERO_GUARD_EN replaces an all-zero seed/state with DEFAULT_SEED.
module prng_lfsr_core #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(16'hACE1),
  parameter int                CHUNK_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               adv,
  output logic [CHUNK_W-1:0] chunk
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] cur;
  logic [LFSR_W-1:0] load_val;
  logic              fb;

`ifdef PRNG_ZERO_GUARD_EN
  assign cur      = (lfsr == '0) ? DEFAULT_SEED : lfsr;
  assign load_val = (seed == '0) ? DEFAULT_SEED : seed;
`else
  assign cur      = lfsr;
  assign load_val = seed;
`endif

  assign fb    = ^(cur & TAPS);
  assign chunk = cur[CHUNK_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= DEFAULT_SEED;
    end else if (load) begin
      lfsr <= load_val;
    end else if (adv) begin
      lfsr <= {cur[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/prng_stream_gen.sv
// Packs CHUNK_W LFSR bits per step into OUT_W words and streams word_count words, then pulses done.
// Build option PRNG_ZERO_GUARD_EN enables the all-zero seed/state guard in the LFSR core.
module prng_stream_gen
  import prng_pkg::*;
#(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(PRNG_DEF_TAPS),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(PRNG_DEF_SEED),
  parameter int                CHUNK_W      = 4,
  parameter int                OUT_W        = 16,
  parameter int                CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              loadseed,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  word_count,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int STEPS = OUT_W / CHUNK_W;
  localparam int SCW   = (STEPS > 1) ? $clog2(STEPS) : 1;

  prng_state_t        state_q, state_d;
  logic [SCW-1:0]     step_cnt;
  logic [CNT_W-1:0]   remaining;
  logic [OUT_W-1:0]   acc, acc_next;
  logic [CHUNK_W-1:0] chunk;
  logic               adv, fire, last_step;

  prng_lfsr_core #(
    .LFSR_W      (LFSR_W),
    .TAPS        (TAPS),
    .DEFAULT_SEED(DEFAULT_SEED),
    .CHUNK_W     (CHUNK_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (loadseed),
    .seed (seed),
    .adv  (adv),
    .chunk(chunk)
  );

  assign acc_next  = (acc << CHUNK_W) | OUT_W'(chunk);
  assign last_step = (step_cnt == SCW'(STEPS - 1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    fire    = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: if (start) state_d = (word_count == '0) ? DONE : GEN;
        GEN: begin
          adv = 1'b1;
          if (last_step) state_d = HOLD;
        end
        HOLD: if (out_valid && out_ready) begin
          fire    = 1'b1;
          state_d = (remaining == CNT_W'(1)) ? DONE : GEN;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || loadseed) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // out_data is left untouched by loadseed; it only changes when a new word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      step_cnt  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (loadseed) begin
      acc       <= '0;
      step_cnt  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (state_q == IDLE && start) begin
        remaining <= word_count;
        acc       <= '0;
        step_cnt  <= '0;
      end
      if (adv) begin
        acc <= acc_next;
        if (last_step) begin
          out_data  <= acc_next;
          out_valid <= 1'b1;
          step_cnt  <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
      if (fire) begin
        out_valid <= 1'b0;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule
